// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem
//  Purpose  : EX/MEM pipeline register followed by the MEM stage: a
//             1024x32 data memory with a combinational read path, a
//             store-data forwarding mux and misalignment detection.
//  Ports    : clk, reset (async, active-low), clr (synchronous flush to NOP)
//             *_EX        : values leaving EX, latched into the MEM register
//             wbdata      : WB-stage value, used as store data when rt_fwd_M=1
//             *_MEM       : latched pipeline values
//             memout_MEM  : extended load data (0 for non-loads / errors)
//             MEM_load, MEM_store, addr_err : decode of the latched instruction
//  Options  : EX_MEM_SUBWORD_EN enables SB/SH/LB/LBU/LH/LHU; without it
//             those opcodes behave as NOPs.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [31:0] Instr_EX,
    input  logic [31:0] PC_EX,
    input  logic [31:0] aluresult_EX,
    input  logic [31:0] rtdata_EX,
    input  logic [31:0] pc8_EX,
    input  logic [31:0] wbdata,
    input  logic        rt_fwd_M,
    output logic [31:0] Instr_MEM,
    output logic [31:0] PC_MEM,
    output logic [31:0] aluresult_MEM,
    output logic [31:0] pc8_MEM,
    output logic [31:0] memout_MEM,
    output logic        MEM_load,
    output logic        MEM_store,
    output logic        addr_err
);

    localparam int unsigned c_DEPTH  = 1024;
    localparam logic [5:0]  c_OP_LW  = 6'h23;
    localparam logic [5:0]  c_OP_SW  = 6'h2b;
`ifdef EX_MEM_SUBWORD_EN
    localparam logic [5:0]  c_OP_LB  = 6'h20;
    localparam logic [5:0]  c_OP_LH  = 6'h21;
    localparam logic [5:0]  c_OP_LBU = 6'h24;
    localparam logic [5:0]  c_OP_LHU = 6'h25;
    localparam logic [5:0]  c_OP_SB  = 6'h28;
    localparam logic [5:0]  c_OP_SH  = 6'h29;
`endif

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [31:0] r_rtdata;
    logic [31:0] r_pc8;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_alu    <= '0;
            r_rtdata <= '0;
            r_pc8    <= '0;
        end else if (clr) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_alu    <= '0;
            r_rtdata <= '0;
            r_pc8    <= '0;
        end else begin
            r_instr  <= Instr_EX;
            r_pc     <= PC_EX;
            r_alu    <= aluresult_EX;
            r_rtdata <= rtdata_EX;
            r_pc8    <= pc8_EX;
        end
    end

    assign Instr_MEM     = r_instr;
    assign PC_MEM        = r_pc;
    assign aluresult_MEM = r_alu;
    assign pc8_MEM       = r_pc8;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic       w_lw, w_sw, w_lb, w_lbu, w_lh, w_lhu, w_sb, w_sh;
    logic       w_load, w_store, w_misalign, w_we;
    logic [9:0] w_index;

    assign w_op    = r_instr[31:26];
    assign w_index = r_alu[11:2];
    assign w_lw    = (w_op == c_OP_LW);
    assign w_sw    = (w_op == c_OP_SW);
`ifdef EX_MEM_SUBWORD_EN
    assign w_lb    = (w_op == c_OP_LB);
    assign w_lbu   = (w_op == c_OP_LBU);
    assign w_lh    = (w_op == c_OP_LH);
    assign w_lhu   = (w_op == c_OP_LHU);
    assign w_sb    = (w_op == c_OP_SB);
    assign w_sh    = (w_op == c_OP_SH);
`else
    assign w_lb    = 1'b0;
    assign w_lbu   = 1'b0;
    assign w_lh    = 1'b0;
    assign w_lhu   = 1'b0;
    assign w_sb    = 1'b0;
    assign w_sh    = 1'b0;
`endif

    assign w_load     = w_lw | w_lb | w_lbu | w_lh | w_lhu;
    assign w_store    = w_sw | w_sb | w_sh;
    // Byte accesses can never be misaligned.
    assign w_misalign = ((w_lw | w_sw) & (r_alu[1:0] != 2'b00))
                      | ((w_lh | w_lhu | w_sh) & r_alu[0]);
    assign w_we       = w_store & ~w_misalign;

    assign MEM_load  = w_load;
    assign MEM_store = w_store;
    assign addr_err  = w_misalign;

    // ------------------------------------------------------------------
    // Store data path: byte enables and lane-replicated write data
    // ------------------------------------------------------------------
    logic [31:0] w_st_src;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_bitmask;

    assign w_st_src = rt_fwd_M ? wbdata : r_rtdata;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_st_src;
        if (w_sw) begin
            w_be = 4'b1111;
        end
        if (w_sb) begin
            w_be    = 4'b0001 << r_alu[1:0];
            w_wdata = {4{w_st_src[7:0]}};
        end
        if (w_sh) begin
            w_be    = r_alu[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_st_src[15:0]}};
        end
    end

    assign w_bitmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    // ------------------------------------------------------------------
    // Data memory: one register per word so the whole array clears on
    // the asynchronous reset, which also aborts any pending write.
    // ------------------------------------------------------------------
    logic [31:0] w_mem [0:c_DEPTH-1];

    genvar g;
    generate
        for (g = 0; g < c_DEPTH; g++) begin : g_word
            logic [31:0] r_word;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_word <= '0;
                end else if (w_we && (w_index == 10'(g))) begin
                    r_word <= (r_word & ~w_bitmask) | (w_wdata & w_bitmask);
                end
            end
            assign w_mem[g] = r_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_word;
    assign w_rd_word = w_mem[w_index];

`ifdef EX_MEM_SUBWORD_EN
    logic [31:0] w_rd_shift;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    assign w_rd_shift = w_rd_word >> {r_alu[1:0], 3'b000};
    assign w_rd_byte  = w_rd_shift[7:0];
    assign w_rd_half  = r_alu[1] ? w_rd_word[31:16] : w_rd_word[15:0];
`endif

    always_comb begin
        memout_MEM = '0;
        if (!w_misalign) begin
            if (w_lw) begin
                memout_MEM = w_rd_word;
            end
`ifdef EX_MEM_SUBWORD_EN
            if (w_lb) begin
                memout_MEM = {{24{w_rd_byte[7]}}, w_rd_byte};
            end
            if (w_lbu) begin
                memout_MEM = {24'h0, w_rd_byte};
            end
            if (w_lh) begin
                memout_MEM = {{16{w_rd_half[15]}}, w_rd_half};
            end
            if (w_lhu) begin
                memout_MEM = {16'h0, w_rd_half};
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem
//  Purpose  : Self-checking bench for ex_mem: directed scenarios followed by
//             randomized traffic, compared against a byte-lane memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [31:0] Instr_EX, PC_EX, aluresult_EX, rtdata_EX, pc8_EX, wbdata;
    logic        rt_fwd_M;
    logic [31:0] Instr_MEM, PC_MEM, aluresult_MEM, pc8_MEM, memout_MEM;
    logic        MEM_load, MEM_store, addr_err;

    ex_mem dut (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .Instr_EX      (Instr_EX),
        .PC_EX         (PC_EX),
        .aluresult_EX  (aluresult_EX),
        .rtdata_EX     (rtdata_EX),
        .pc8_EX        (pc8_EX),
        .wbdata        (wbdata),
        .rt_fwd_M      (rt_fwd_M),
        .Instr_MEM     (Instr_MEM),
        .PC_MEM        (PC_MEM),
        .aluresult_MEM (aluresult_MEM),
        .pc8_MEM       (pc8_MEM),
        .memout_MEM    (memout_MEM),
        .MEM_load      (MEM_load),
        .MEM_store     (MEM_store),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

`ifdef EX_MEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: memory image plus the instruction currently in MEM.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] m_instr, m_pc, m_alu, m_rt, m_pc8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got %08h expected %08h", tag, $time, got, exp);
        end
    endtask

    // Access size in bytes, 0 when the opcode does not touch memory.
    function automatic int acc_size(input logic [5:0] op);
        case (op)
            6'h23, 6'h2b:        return 4;
            6'h21, 6'h25, 6'h29: return SUB ? 2 : 0;
            6'h20, 6'h24, 6'h28: return SUB ? 1 : 0;
            default:             return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (acc_size(op) != 0) && (op == 6'h2b || op == 6'h28 || op == 6'h29);
    endfunction

    function automatic bit is_load(input logic [5:0] op);
        return (acc_size(op) != 0) && !is_store(op);
    endfunction

    function automatic bit misaligned(input logic [5:0] op, input logic [31:0] a);
        int sz;
        sz = acc_size(op);
        return (sz != 0) && ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] exp_load_data();
        logic [5:0]  op;
        logic [31:0] word, sh;
        op   = m_instr[31:26];
        word = ref_mem[m_alu[11:2]];
        sh   = word >> (8 * m_alu[1:0]);
        if (!is_load(op) || misaligned(op, m_alu)) return 32'h0;
        case (op)
            6'h20:   return {{24{sh[7]}}, sh[7:0]};
            6'h24:   return {24'h0, sh[7:0]};
            6'h21:   return {{16{sh[15]}}, sh[15:0]};
            6'h25:   return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    task automatic check_model();
        logic [5:0] op;
        op = m_instr[31:26];
        check("instr",   Instr_MEM,     m_instr);
        check("pc",      PC_MEM,        m_pc);
        check("alu",     aluresult_MEM, m_alu);
        check("pc8",     pc8_MEM,       m_pc8);
        check("load",    {31'h0, MEM_load},  {31'h0, is_load(op)});
        check("store",   {31'h0, MEM_store}, {31'h0, is_store(op)});
        check("addrerr", {31'h0, addr_err},  {31'h0, misaligned(op, m_alu)});
        check("memout",  memout_MEM,    exp_load_data());
    endtask

    // One clock edge of the model: the MEM instruction completes, then the
    // pipeline register captures the EX values (or a bubble).
    task automatic model_edge(input logic c, input logic [31:0] ins, pc, alu, rt, p8, wb,
                              input logic fwd);
        logic [5:0]  op;
        logic [31:0] d;
        op = m_instr[31:26];
        d  = fwd ? wb : m_rt;
        if (is_store(op) && !misaligned(op, m_alu)) begin
            for (int k = 0; k < acc_size(op); k++)
                ref_mem[m_alu[11:2]][8 * (m_alu[1:0] + k) +: 8] = d[8 * k +: 8];
        end
        if (c) begin
            m_instr = '0; m_pc = '0; m_alu = '0; m_rt = '0; m_pc8 = '0;
        end else begin
            m_instr = ins; m_pc = pc; m_alu = alu; m_rt = rt; m_pc8 = p8;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        m_instr = '0; m_pc = '0; m_alu = '0; m_rt = '0; m_pc8 = '0;
    endtask

    // Entered just after a falling edge; returns at the next falling edge.
    task automatic step(input logic c, input logic [31:0] ins, pc, alu, rt, p8, wb,
                        input logic fwd);
        clr = c; Instr_EX = ins; PC_EX = pc; aluresult_EX = alu;
        rtdata_EX = rt; pc8_EX = p8; wbdata = wb; rt_fwd_M = fwd;
        model_edge(c, ins, pc, alu, rt, p8, wb, fwd);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    // Short low pulse between two rising edges.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst_instr", Instr_MEM, 32'h0);
        check_model();
        #1 reset = 1'b1;
    endtask

    function automatic logic [31:0] ins_of(input logic [5:0] op);
        return {op, 26'h0155aa5};
    endfunction

    // Simple directed wrapper: no flush, no forwarding.
    task automatic op_step(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt);
        step(1'b0, ins_of(op), 32'h0040_0000 + alu, alu, rt, 32'h0040_0008 + alu, 32'h0, 1'b0);
    endtask

    logic [5:0] op_pool [0:9];

    initial begin
        op_pool = '{6'h23, 6'h2b, 6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29, 6'h00, 6'h0f};
        clr = 1'b0; Instr_EX = '0; PC_EX = '0; aluresult_EX = '0; rtdata_EX = '0;
        pc8_EX = '0; wbdata = '0; rt_fwd_M = 1'b0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        Instr_EX = ins_of(6'h2b); aluresult_EX = 32'h44; PC_EX = 32'h1234;
        repeat (2) @(negedge clk);
        check_model();
        check("rst_pc", PC_MEM, 32'h0);
        reset = 1'b1;

        // Store then load of the same word.
        op_step(6'h2b, 32'h10, 32'h12345678);
        op_step(6'h23, 32'h10, 32'h0);
        check("sw_lw", memout_MEM, 32'h12345678);

        // Forwarded store data replaces the latched rt value.
        op_step(6'h2b, 32'h10, 32'h0BADF00D);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEBABE, 1'b1);
        op_step(6'h23, 32'h10, 32'h0);
        check("fwd_lw", memout_MEM, 32'hCAFEBABE);

        // Misaligned word accesses.
        op_step(6'h23, 32'h13, 32'h0);
        check("mis_err", {31'h0, addr_err}, 32'h1);
        check("mis_out", memout_MEM, 32'h0);
        op_step(6'h2b, 32'h13, 32'hDEADBEEF);
        op_step(6'h23, 32'h10, 32'h0);
        check("mis_sw", memout_MEM, 32'hCAFEBABE);

        // Flush of a store: bubble enters MEM and nothing is written.
        step(1'b1, ins_of(6'h2b), 32'h1, 32'h10, 32'h11111111, 32'h9, 32'h0, 1'b0);
        check("clr_ins", Instr_MEM, 32'h0);
        op_step(6'h23, 32'h10, 32'h0);
        check("clr_lw", memout_MEM, 32'hCAFEBABE);

        // A store already in MEM completes even while clr is high.
        op_step(6'h2b, 32'h30, 32'h600DCAFE);
        step(1'b1, ins_of(6'h23), 32'h0, 32'h30, 32'h0, 32'h0, 32'h0, 1'b0);
        op_step(6'h23, 32'h30, 32'h0);
        check("clr_done", memout_MEM, 32'h600DCAFE);

        // Sub-word accesses.
        op_step(6'h2b, 32'h20, 32'h80FF7F01);
`ifdef EX_MEM_SUBWORD_EN
        op_step(6'h20, 32'h23, 32'h0);
        check("lb",  memout_MEM, 32'hFFFFFF80);
        op_step(6'h24, 32'h23, 32'h0);
        check("lbu", memout_MEM, 32'h00000080);
        op_step(6'h21, 32'h20, 32'h0);
        check("lh",  memout_MEM, 32'h00007F01);
        op_step(6'h25, 32'h22, 32'h0);
        check("lhu", memout_MEM, 32'h000080FF);
        op_step(6'h28, 32'h21, 32'h000000AA);
        op_step(6'h23, 32'h20, 32'h0);
        check("sb",  memout_MEM, 32'h80FFAA01);
`else
        op_step(6'h20, 32'h23, 32'h0);
        check("lb_nop",  {31'h0, MEM_load}, 32'h0);
        check("lb_out",  memout_MEM, 32'h0);
        op_step(6'h28, 32'h21, 32'h000000AA);
        check("sb_nop",  {31'h0, MEM_store}, 32'h0);
        op_step(6'h23, 32'h20, 32'h0);
        check("sb_word", memout_MEM, 32'h80FF7F01);
`endif

        // Reset pulse while a store sits in MEM: write aborted, memory cleared.
        op_step(6'h2b, 32'h40, 32'h5555AAAA);
        reset_pulse();
        op_step(6'h23, 32'h40, 32'h0);
        check("rst_lw40", memout_MEM, 32'h0);
        op_step(6'h23, 32'h10, 32'h0);
        check("rst_lw10", memout_MEM, 32'h0);

        // Randomized traffic over a small address window to get many hits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] alu, ins;
            logic [1:0]  lo;
            ins = {op_pool[$urandom_range(0, 9)], 26'($urandom)};
            lo  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            alu = {20'($urandom), 7'h0, 3'($urandom_range(0, 7)), lo};
            step(($urandom_range(0, 9) == 0), ins, $urandom, alu, $urandom, $urandom,
                 $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL be built on one clock and one reset; the reset is asynchronous and active-low.
REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  clr  in  1  synchronous flush: load a bubble (NOP) instead of the EX values
  Instr_EX  in  32  instruction leaving EX
  PC_EX  in  32  PC of that instruction
  aluresult_EX  in  32  ALU / HI / LO result (effective address for loads and stores)
  rtdata_EX  in  32  forwarded rt value (store data)
  pc8_EX  in  32  PC+8 link value
  wbdata  in  32  value being written back by the WB stage
  rt_fwd_M  in  1  1 = replace the latched store data with wbdata
  Instr_MEM  out  32  latched instruction
  PC_MEM  out  32  latched PC
  aluresult_MEM  out  32  latched ALU result
  pc8_MEM  out  32  latched PC+8
  memout_MEM  out  32  extended load data
  MEM_load  out  1  latched instruction is a load
  MEM_store  out  1  latched instruction is a store
  addr_err  out  1  latched load or store is misaligned

Function
REQ-003 On each rising clk edge with clr=0, the block SHALL latch Instr_EX, PC_EX, aluresult_EX, rtdata_EX and pc8_EX into the MEM pipeline register.
REQ-004 On each rising clk edge with clr=1, the block SHALL latch 0 into every pipeline register field, so the stage carries a NOP.
REQ-005 The block SHALL contain a 1024x32 data memory indexed by aluresult_MEM[11:2]; address bits [31:12] SHALL be ignored.
REQ-006 Store data SHALL be wbdata when rt_fwd_M=1, otherwise the latched rtdata.
REQ-007 SW (opcode 0x2b) SHALL write the full word at the rising edge that ends the instruction's MEM cycle.
REQ-008 LW (opcode 0x23) SHALL drive memout_MEM combinationally in the same cycle, with zero added latency after the pipeline register.
REQ-009 A word access with aluresult_MEM[1:0]!=0, or a halfword access with aluresult_MEM[0]=1, SHALL assert addr_err, suppress the write and drive memout_MEM=0.
REQ-010 When a store writes an address, a load of that address in the next cycle SHALL return the new data.
REQ-011 MEM_load and MEM_store SHALL be decoded combinationally from Instr_MEM[31:26].
REQ-012 For every non-load instruction, memout_MEM SHALL be 0.
REQ-013 While clr=1, the bubble it inserts SHALL never write memory; the instruction already in MEM SHALL still complete its write at the same edge.

Reset
REQ-014 Asserting reset (low) SHALL immediately clear all pipeline registers, so all outputs go to 0 and addr_err/MEM_load/MEM_store read 0.
REQ-015 Asserting reset SHALL clear every data-memory word to 0.
REQ-016 If reset is asserted mid-store, that write SHALL not occur.
REQ-017 Release of reset SHALL take effect at the first rising clk edge after reset goes high.

Configuration
REQ-018 With macro EX_MEM_SUBWORD_EN defined, the block SHALL support the following sub-word accesses:
  SB (0x28): byte write selected by addr[1:0]
  SH (0x29): halfword write selected by addr[1]
  LB (0x20) / LBU (0x24): byte load, sign- / zero-extended
  LH (0x21) / LHU (0x25): halfword load, sign- / zero-extended
  all sub-word accesses are little-endian.
REQ-019 Without EX_MEM_SUBWORD_EN, opcodes 0x20, 0x21, 0x24, 0x25, 0x28 and 0x29 SHALL behave as NOPs: no write, MEM_load=MEM_store=0, memout_MEM=0.

Verification
REQ-020 Scenario: SW with rt=0x12345678 to address 0x10, then LW from 0x10 -> memout_MEM=0x12345678 in the LW's MEM cycle.
REQ-021 Scenario: SW to 0x10 with rt_fwd_M=1 and wbdata=0xCAFEBABE -> a later LW from 0x10 returns 0xCAFEBABE.
REQ-022 Scenario: LW from 0x13 -> addr_err=1 and memout_MEM=0; SW to 0x13 -> the memory word is unchanged.
REQ-023 Scenario: clr=1 while Instr_EX=SW -> Instr_MEM=0 and no write occurs.
REQ-024 Scenario: with EX_MEM_SUBWORD_EN, word 0x80FF7F01 at 0x20 -> LB 0x23 = 0xFFFFFF80, LBU 0x23 = 0x00000080, LH 0x20 = 0x00007F01, LHU 0x22 = 0x000080FF; SB 0xAA to 0x21 -> word = 0x80FFAA01.
REQ-025 Scenario: reset pulsed low between two clock edges after a store -> outputs are 0 immediately and a later LW of that address returns 0.
